// File: rtl/sum_drain.sv
// Two-deep vector buffer that serializes accumulator lanes into requantized words.
// Optional macro SUM_DRAIN_RELU_EN clamps negative results to zero.
module sum_drain #(
    parameter int BITS          = 16,
    parameter int KERNEL        = 7,
    parameter int FEATURES      = 12,
    parameter int OVERHEAD_BITS = 12,
    parameter int FRAC_SHIFT    = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_valid,
    output logic in_ready,
    input  logic [(FEATURES-KERNEL+1)*(2*BITS+OVERHEAD_BITS)-1:0] sums,
    output logic [BITS-1:0] out_data,
    output logic out_valid,
    input  logic out_ready,
    output logic out_last,
    output logic out_sat,
    output logic drop_err
);

    localparam int SW = 2*BITS + OVERHEAD_BITS;
    localparam int N  = FEATURES - KERNEL + 1;
    localparam int LW = (N > 1) ? $clog2(N) : 1;
    localparam logic [LW-1:0] LAST = LW'(N-1);

    localparam logic signed [SW:0] RND  = (SW+1)'(1) <<< (FRAC_SHIFT-1);
    localparam logic signed [SW:0] MAXV =
        {{(SW-BITS+2){1'b0}}, {(BITS-1){1'b1}}};
    localparam logic signed [SW:0] MINV =
        {{(SW-BITS+2){1'b1}}, {(BITS-1){1'b0}}};

    typedef enum logic {
        S_IDLE,
        S_STREAM
    } state_t;

    logic [N*SW-1:0] r_buf [2];
    logic            r_wptr;
    logic            r_rptr;
    logic [1:0]      r_count;
    logic [LW-1:0]   r_lane;
    state_t          r_state;

    logic            w_acc;
    logic            w_hs;
    logic            w_wrap;
    logic            w_more;
    logic [N*SW-1:0] w_src_vec;
    logic [LW-1:0]   w_src_idx;
    logic [SW-1:0]   w_lane;

    logic signed [SW:0] w_ext;
    logic signed [SW:0] w_rnd;
    logic signed [SW:0] w_shf;
    logic            w_hi;
    logic            w_lo;
    logic [BITS-1:0] w_clip;
    logic [BITS-1:0] w_q;

    assign in_ready = (r_count != 2'd2);
    assign w_acc    = in_valid && in_ready;
    assign w_hs     = out_valid && out_ready;
    assign w_wrap   = (r_state == S_STREAM) && w_hs && (r_lane == LAST);
    assign w_more   = (r_count == 2'd2) || w_acc;

    // On a final-lane pop the next word comes from the second entry, or
    // straight from the input when that vector is being accepted this edge.
    always_comb begin
        w_src_vec = r_buf[r_rptr];
        w_src_idx = '0;
        if (r_state == S_STREAM) begin
            if (r_lane == LAST) begin
                if (r_count == 2'd2) begin
                    w_src_vec = r_buf[~r_rptr];
                end else begin
                    w_src_vec = sums;
                end
            end else begin
                w_src_idx = r_lane + 1'b1;
            end
        end
    end

    assign w_lane = w_src_vec[32'(w_src_idx)*SW +: SW];

    assign w_ext = {w_lane[SW-1], w_lane};
    assign w_rnd = w_ext + RND;
    assign w_shf = w_rnd >>> FRAC_SHIFT;
    assign w_hi  = (w_shf > MAXV);
    assign w_lo  = (w_shf < MINV);

    always_comb begin
        w_clip = w_shf[BITS-1:0];
        if (w_hi) begin
            w_clip = {1'b0, {(BITS-1){1'b1}}};
        end else if (w_lo) begin
            w_clip = {1'b1, {(BITS-1){1'b0}}};
        end
    end

`ifdef SUM_DRAIN_RELU_EN
    assign w_q = w_clip[BITS-1] ? '0 : w_clip;
`else
    assign w_q = w_clip;
`endif

    always_ff @(posedge clk) begin
        if (w_acc) begin
            r_buf[r_wptr] <= sums;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr   <= 1'b0;
            r_rptr   <= 1'b0;
            r_count  <= 2'd0;
            drop_err <= 1'b0;
        end else begin
            if (w_acc) begin
                r_wptr <= ~r_wptr;
            end
            if (w_wrap) begin
                r_rptr <= ~r_rptr;
            end
            r_count <= r_count + {1'b0, w_acc} - {1'b0, w_wrap};
            if (in_valid && !in_ready) begin
                drop_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_lane    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_sat   <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (r_count != 2'd0) begin
                        r_state   <= S_STREAM;
                        r_lane    <= '0;
                        out_valid <= 1'b1;
                        out_data  <= w_q;
                        out_sat   <= w_hi || w_lo;
                        out_last  <= (w_src_idx == LAST);
                    end
                end
                S_STREAM: begin
                    if (w_hs) begin
                        if (r_lane != LAST) begin
                            r_lane   <= w_src_idx;
                            out_data <= w_q;
                            out_sat  <= w_hi || w_lo;
                            out_last <= (w_src_idx == LAST);
                        end else if (w_more) begin
                            r_lane   <= '0;
                            out_data <= w_q;
                            out_sat  <= w_hi || w_lo;
                            out_last <= (w_src_idx == LAST);
                        end else begin
                            r_state   <= S_IDLE;
                            r_lane    <= '0;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            out_sat   <= 1'b0;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
